// File: rtl/dvi_pkg.sv
// Shared types and constants for the DVI receive path.
//   rx_state_t  : receive state machine states
//   pixel_t     : one assembled 24-bit pixel
//   fifo_word_t : pixel plus start-of-frame / end-of-line tags as stored in the FIFO
//   GEOM_W      : width of the geometry counters and outputs
package dvi_pkg;

  localparam int unsigned GEOM_W = 12;
  localparam int unsigned HALF_W = 12;

  typedef logic [2*HALF_W-1:0] pixel_t;

  typedef struct packed {
    pixel_t data;
    logic   sof;
    logic   eol;
  } fifo_word_t;

  typedef enum logic [1:0] {
    SEEK,
    FRAME,
    HI,
    DROP
  } rx_state_t;

  // Saturating increment for the geometry counters.
  function automatic logic [GEOM_W-1:0] sat_inc(input logic [GEOM_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a registered, show-ahead output stage.
//   clk, rst_n : clock, asynchronous active-low reset
//   wr_en      : write request (dropped internally if full and not reading)
//   wr_data    : write word
//   full       : DEPTH words held (output register included)
//   rd_en      : consume the word on rd_data when rd_valid
//   rd_data    : head word, held stable until consumed
//   rd_valid   : rd_data holds a valid word
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid
);

  localparam int unsigned AW = $clog2(DEPTH);

  // The head word lives in rd_data; the array holds the up to DEPTH-1 words behind it.
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    mem_cnt;

  logic rd_fire;
  logic head_free;
  logic mem_rd;
  logic mem_wr;
  logic bypass;

  always_comb begin
    rd_fire   = rd_en && rd_valid;
    head_free = !rd_valid || rd_fire;
    full      = rd_valid && (mem_cnt == AW'(DEPTH - 1));
    mem_rd    = head_free && (mem_cnt != '0);
    // An empty array with a free head: the write goes straight to the output register.
    bypass    = head_free && (mem_cnt == '0) && wr_en;
    mem_wr    = wr_en && !bypass && (!full || rd_fire);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      mem_cnt  <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (mem_wr) wr_ptr <= wr_ptr + 1'b1;
      if (mem_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({mem_wr, mem_rd})
        2'b10:   mem_cnt <= mem_cnt + 1'b1;
        2'b01:   mem_cnt <= mem_cnt - 1'b1;
        default: mem_cnt <= mem_cnt;
      endcase
      if (head_free) begin
        if (mem_rd) begin
          rd_data  <= mem[rd_ptr];
          rd_valid <= 1'b1;
        end else if (bypass) begin
          rd_data  <= wr_data;
          rd_valid <= 1'b1;
        end else begin
          rd_valid <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/dvi_receiver.sv
// Receive end of a 12-bit half-pixel DVI-style bus.
// Pairs two half-words into a 24-bit pixel, tags sof/eol, buffers pixels in a
// FIFO and presents them on a valid/ready stream. Also measures frame geometry
// and keeps sticky overflow / half-pixel / hsync status flags.
//   clk, resetn            : bus clock (two cycles per pixel), async active-low reset
//   dvi_de/vs/hs, dvi_d    : input bus; first half is bits [11:0], second [23:12]
//   px_data/sof/eol        : output pixel and tags
//   px_valid, px_ready     : output stream handshake
//   clear_status           : one-cycle pulse clearing the sticky flags
//   overflow               : sticky, pixel lost to a full FIFO
//   half_error             : sticky, de fell after an odd number of halves
//   hs_seen                : sticky, an active hsync edge was observed
//   frame_width/height     : geometry of the last complete frame
//   geom_valid             : one-cycle pulse when the geometry updates
module dvi_receiver
  import dvi_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter bit          VS_ACTIVE_HIGH = 1'b1,
  parameter bit          HS_ACTIVE_HIGH = 1'b1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              dvi_de,
  input  logic              dvi_vs,
  input  logic              dvi_hs,
  input  logic [11:0]       dvi_d,
  output logic [23:0]       px_data,
  output logic              px_sof,
  output logic              px_eol,
  output logic              px_valid,
  input  logic              px_ready,
  input  logic              clear_status,
  output logic              overflow,
  output logic              half_error,
  output logic              hs_seen,
  output logic [GEOM_W-1:0] frame_width,
  output logic [GEOM_W-1:0] frame_height,
  output logic              geom_valid
);

  // ---------------- input stage ----------------
  logic        de_r, de_d;
  logic        vs_a, vs_a_d;
  logic        hs_a, hs_a_d;
  logic [11:0] d_r;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      de_r   <= 1'b0;
      de_d   <= 1'b0;
      vs_a   <= 1'b0;
      vs_a_d <= 1'b0;
      hs_a   <= 1'b0;
      hs_a_d <= 1'b0;
      d_r    <= '0;
    end else begin
      de_r   <= dvi_de;
      de_d   <= de_r;
      // Syncs are stored already normalised to "1 = active".
      vs_a   <= (dvi_vs == VS_ACTIVE_HIGH);
      vs_a_d <= vs_a;
      hs_a   <= (dvi_hs == HS_ACTIVE_HIGH);
      hs_a_d <= hs_a;
      d_r    <= dvi_d;
    end
  end

  logic vs_edge;
  logic hs_edge;
  logic de_fall;

  always_comb begin
    vs_edge = vs_a && !vs_a_d;
    hs_edge = hs_a && !hs_a_d;
    de_fall = de_d && !de_r;
  end

  // ---------------- state machine ----------------
  rx_state_t state, state_nx;

  logic        hold_valid;
  logic        hold_sof;
  pixel_t      hold_data;
  logic [11:0] lo_half;
  logic        sof_pending;

  logic fifo_full;
  logic fifo_rd;
  logic in_frame;
  logic capture_lo;
  logic form_px;
  logic push;
  logic push_eol;
  logic fifo_wr;
  logic drop_px;
  logic half_err_set;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= SEEK;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      SEEK: begin
        if (vs_edge) state_nx = FRAME;
      end
      FRAME: begin
        if (vs_edge)         state_nx = FRAME;
        else if (drop_px)    state_nx = DROP;
        else if (capture_lo) state_nx = HI;
      end
      HI: begin
        if (vs_edge)      state_nx = FRAME;
        else if (drop_px) state_nx = DROP;
        else              state_nx = FRAME;
      end
      DROP: begin
        if (vs_edge) state_nx = FRAME;
      end
      default: state_nx = SEEK;
    endcase
  end

  // vs_edge outranks pixel assembly: a half in flight at a new frame is discarded.
  always_comb begin
    fifo_rd      = px_valid && px_ready;
    in_frame     = (state == FRAME) || (state == HI);
    capture_lo   = (state == FRAME) && de_r && !vs_edge;
    form_px      = (state == HI) && de_r && !vs_edge;
    half_err_set = (state == HI) && !de_r && !vs_edge;
    // A held pixel leaves when its successor completes (not last in line) or
    // when the line/frame ends under it (last in line).
    push         = in_frame && hold_valid && (form_px || de_fall || vs_edge);
    push_eol     = !form_px;
    fifo_wr      = push && (!fifo_full || fifo_rd);
    drop_px      = push && fifo_full && !fifo_rd;
  end

  // ---------------- holding register ----------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lo_half     <= '0;
      hold_data   <= '0;
      hold_sof    <= 1'b0;
      hold_valid  <= 1'b0;
      sof_pending <= 1'b0;
    end else begin
      if (capture_lo) lo_half <= d_r;

      if (drop_px) begin
        hold_valid <= 1'b0;
      end else if (form_px) begin
        hold_data  <= {d_r, lo_half};
        hold_sof   <= sof_pending;
        hold_valid <= 1'b1;
      end else if (push) begin
        hold_valid <= 1'b0;
      end

      if (vs_edge)      sof_pending <= 1'b1;
      else if (form_px) sof_pending <= 1'b0;
    end
  end

  // ---------------- pixel FIFO ----------------
  fifo_word_t wr_word;
  fifo_word_t rd_word;

  always_comb begin
    wr_word.data = hold_data;
    wr_word.sof  = hold_sof;
    wr_word.eol  = push_eol;
  end

  sync_fifo #(
    .WIDTH ($bits(fifo_word_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (resetn),
    .wr_en    (fifo_wr),
    .wr_data  (wr_word),
    .full     (fifo_full),
    .rd_en    (px_ready),
    .rd_data  (rd_word),
    .rd_valid (px_valid)
  );

  always_comb begin
    px_data = rd_word.data;
    px_sof  = rd_word.sof;
    px_eol  = rd_word.eol;
  end

  // ---------------- geometry ----------------
  logic [GEOM_W-1:0] pix_cnt;
  logic [GEOM_W-1:0] line_cnt;
  logic [GEOM_W-1:0] last_width;
  logic              geom_upd;

  always_comb begin
    geom_upd = vs_edge && in_frame && (line_cnt != '0);
  end

  // last_width tracks the running pixel count of the most recent line that
  // received a pixel, so it already holds the last line's width at vs time.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pix_cnt    <= '0;
      line_cnt   <= '0;
      last_width <= '0;
    end else if (vs_edge) begin
      pix_cnt    <= '0;
      line_cnt   <= '0;
      last_width <= '0;
    end else if (form_px) begin
      pix_cnt    <= sat_inc(pix_cnt);
      last_width <= sat_inc(pix_cnt);
      if (pix_cnt == '0) line_cnt <= sat_inc(line_cnt);
    end else if (de_fall) begin
      pix_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      frame_width  <= '0;
      frame_height <= '0;
      geom_valid   <= 1'b0;
    end else begin
      geom_valid <= geom_upd;
      if (geom_upd) begin
        frame_width  <= last_width;
        frame_height <= line_cnt;
      end
    end
  end

  // ---------------- sticky status ----------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      overflow   <= 1'b0;
      half_error <= 1'b0;
      hs_seen    <= 1'b0;
    end else begin
      overflow   <= drop_px      || (overflow   && !clear_status);
      half_error <= half_err_set || (half_error && !clear_status);
      hs_seen    <= hs_edge      || (hs_seen    && !clear_status);
    end
  end

endmodule

// File: tb/tb_dvi_receiver.sv
// Self-checking bench for dvi_receiver: randomized half-pixel data, a
// frame/line-level reference model producing the expected pixel stream and
// geometry, and a stream monitor that also checks data stability under stall.
module tb_dvi_receiver;
  import dvi_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        dvi_de, dvi_vs, dvi_hs;
  logic [11:0] dvi_d;
  logic [23:0] px_data;
  logic        px_sof, px_eol, px_valid;
  logic        px_ready;
  logic        clear_status;
  logic        overflow, half_error, hs_seen;
  logic [11:0] frame_width, frame_height;
  logic        geom_valid;

  dvi_receiver #(
    .FIFO_DEPTH     (16),
    .VS_ACTIVE_HIGH (1'b1),
    .HS_ACTIVE_HIGH (1'b1)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .dvi_de       (dvi_de),
    .dvi_vs       (dvi_vs),
    .dvi_hs       (dvi_hs),
    .dvi_d        (dvi_d),
    .px_data      (px_data),
    .px_sof       (px_sof),
    .px_eol       (px_eol),
    .px_valid     (px_valid),
    .px_ready     (px_ready),
    .clear_status (clear_status),
    .overflow     (overflow),
    .half_error   (half_error),
    .hs_seen      (hs_seen),
    .frame_width  (frame_width),
    .frame_height (frame_height),
    .geom_valid   (geom_valid)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model state ----------------
  fifo_word_t  exp_q[$];
  bit          in_frame   = 1'b0;
  bit          dropping   = 1'b0;
  bit          sof_next   = 1'b0;
  int          lines      = 0;
  int          last_w     = 0;
  int          exp_geom_n = 0;
  int          exp_w      = 0;
  int          exp_h      = 0;
  logic [11:0] pat        = '0;

  // ---------------- monitor ----------------
  int          n_extra  = 0;
  int          geom_n   = 0;
  logic [11:0] obs_w    = '0;
  logic [11:0] obs_h    = '0;
  bit          stall_p  = 1'b0;
  logic [25:0] prev_w   = '0;
  int          ready_mode = 0;  // 0 always, 1 toggle, 2 held low

  always @(negedge clk) begin
    if (resetn) begin
      if (stall_p) begin
        check("hold_valid", 32'(px_valid), 32'd1);
        check("hold_word", 32'({px_data, px_sof, px_eol}), 32'(prev_w));
      end
      if (px_valid && px_ready) begin
        if (exp_q.size() == 0) begin
          n_extra++;
        end else begin
          fifo_word_t e;
          e = exp_q.pop_front();
          check("px_data", 32'(px_data), 32'(e.data));
          check("px_sof", 32'(px_sof), 32'(e.sof));
          check("px_eol", 32'(px_eol), 32'(e.eol));
        end
      end
      if (geom_valid) begin
        geom_n++;
        obs_w = frame_width;
        obs_h = frame_height;
      end
      stall_p = px_valid && !px_ready;
      prev_w  = {px_data, px_sof, px_eol};
    end else begin
      stall_p = 1'b0;
    end
  end

  initial begin
    px_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       px_ready = 1'b1;
        1:       px_ready = ~px_ready;
        default: px_ready = 1'b0;
      endcase
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_line(input int halves, input bit use_pat, input int max_px);
    logic [11:0] h[$];
    fifo_word_t  e;
    int          npx;
    npx = halves / 2;
    for (int i = 0; i < halves; i++) begin
      if (use_pat) begin
        pat = pat + 12'd1;
        h.push_back(pat);
      end else begin
        h.push_back(12'($urandom));
      end
    end
    if (in_frame && !dropping) begin
      if (npx > 0) begin
        lines++;
        last_w = npx;
      end
      for (int p = 0; p < npx && p < max_px; p++) begin
        e.data   = {h[2*p+1], h[2*p]};
        e.sof    = sof_next;
        e.eol    = (p == npx - 1);
        sof_next = 1'b0;
        exp_q.push_back(e);
      end
      if (npx > max_px) dropping = 1'b1;
    end
    dvi_de = 1'b1;
    for (int i = 0; i < halves; i++) begin
      dvi_d = h[i];
      tick();
    end
    dvi_de = 1'b0;
    dvi_d  = '0;
    repeat (4) tick();
  endtask

  task automatic send_vs();
    if (in_frame && !dropping && lines > 0) begin
      exp_geom_n++;
      exp_w = last_w;
      exp_h = lines;
    end
    in_frame = 1'b1;
    dropping = 1'b0;
    sof_next = 1'b1;
    lines    = 0;
    last_w   = 0;
    dvi_vs = 1'b1;
    repeat (2) tick();
    dvi_vs = 1'b0;
    repeat (4) tick();
  endtask

  task automatic check_geom();
    check("geom_count", 32'(geom_n), 32'(exp_geom_n));
    if (exp_geom_n > 0) begin
      check("frame_width", 32'(obs_w), 32'(exp_w));
      check("frame_height", 32'(obs_h), 32'(exp_h));
    end
  endtask

  task automatic wait_drain(input string tag);
    for (int c = 0; c < 3000 && exp_q.size() != 0; c++) tick();
    repeat (8) tick();
    check(tag, 32'(exp_q.size()), 32'd0);
    check("extra_px", 32'(n_extra), 32'd0);
  endtask

  task automatic pulse_clear();
    clear_status = 1'b1;
    tick();
    clear_status = 1'b0;
    tick();
  endtask

  task automatic check_all_zero();
    check("rst_px_data", 32'(px_data), 32'd0);
    check("rst_px_sof", 32'(px_sof), 32'd0);
    check("rst_px_eol", 32'(px_eol), 32'd0);
    check("rst_px_valid", 32'(px_valid), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_half_error", 32'(half_error), 32'd0);
    check("rst_hs_seen", 32'(hs_seen), 32'd0);
    check("rst_width", 32'(frame_width), 32'd0);
    check("rst_height", 32'(frame_height), 32'd0);
    check("rst_geom_valid", 32'(geom_valid), 32'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    resetn = 1'b0;
    dvi_de = 1'b0;
    dvi_vs = 1'b0;
    dvi_hs = 1'b0;
    dvi_d  = '0;
    clear_status = 1'b0;
    repeat (3) tick();
    check_all_zero();
    resetn = 1'b1;
    repeat (2) tick();

    // Stream before any vsync: nothing delivered, first vsync gives no geometry.
    send_line(8, 1'b0, 4096);
    send_line(8, 1'b0, 4096);
    send_vs();
    check_geom();
    wait_drain("pre_vs_drain");

    // Two lines of four pixels with counting halves.
    pat = '0;
    send_line(8, 1'b1, 4096);
    send_line(8, 1'b1, 4096);
    wait_drain("basic_drain");
    send_vs();
    check_geom();

    // Odd half count: one pixel with eol, half_error raised then cleared.
    send_line(3, 1'b0, 4096);
    wait_drain("half_drain");
    check("half_error_set", 32'(half_error), 32'd1);
    pulse_clear();
    check("half_error_clr", 32'(half_error), 32'd0);
    send_vs();
    check_geom();

    // hsync edge detection.
    check("hs_seen_idle", 32'(hs_seen), 32'd0);
    dvi_hs = 1'b1;
    repeat (2) tick();
    dvi_hs = 1'b0;
    repeat (2) tick();
    check("hs_seen_set", 32'(hs_seen), 32'd1);
    pulse_clear();
    check("hs_seen_clr", 32'(hs_seen), 32'd0);

    // Overflow: stalled output, 40-pixel line, only the first 16 survive.
    ready_mode = 2;
    repeat (2) tick();
    send_line(80, 1'b0, 16);
    send_line(10, 1'b0, 4096);
    check("overflow_set", 32'(overflow), 32'd1);
    ready_mode = 0;
    wait_drain("ovf_drain");
    pulse_clear();
    check("overflow_clr", 32'(overflow), 32'd0);
    send_vs();
    check_geom();
    for (int l = 0; l < 3; l++) send_line(10, 1'b0, 4096);
    wait_drain("post_ovf_drain");
    send_vs();
    check_geom();
    check("no_overflow", 32'(overflow), 32'd0);

    // Ready toggling every cycle across three 16x4 frames.
    ready_mode = 1;
    for (int f = 0; f < 3; f++) begin
      for (int l = 0; l < 4; l++) send_line(32, 1'b0, 4096);
      send_vs();
      check_geom();
    end
    wait_drain("toggle_drain");
    ready_mode = 0;
    repeat (2) tick();

    // Reset mid-line with pixels buffered and a sticky flag set.
    ready_mode = 2;
    repeat (2) tick();
    dvi_hs = 1'b1;
    repeat (2) tick();
    dvi_hs = 1'b0;
    dvi_de = 1'b1;
    for (int i = 0; i < 9; i++) begin
      dvi_d = 12'($urandom);
      tick();
    end
    check("pre_rst_valid", 32'(px_valid), 32'd1);
    check("pre_rst_hs", 32'(hs_seen), 32'd1);
    resetn = 1'b0;
    #1;
    check_all_zero();
    exp_q.delete();
    in_frame = 1'b0;
    dropping = 1'b0;
    sof_next = 1'b0;
    lines    = 0;
    dvi_de   = 1'b0;
    dvi_d    = '0;
    ready_mode = 0;
    repeat (3) tick();
    resetn = 1'b1;
    repeat (2) tick();
    send_line(8, 1'b0, 4096);
    wait_drain("post_rst_no_vs");
    send_vs();
    check_geom();
    send_line(8, 1'b0, 4096);
    wait_drain("post_rst_frame");
    send_vs();
    check_geom();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dvi_receiver.md
Name: dvi_receiver

Overview:
- Receive end of the 12-bit parallel DVI-style video bus: dvi_de, dvi_vs, dvi_hs, dvi_d[11:0].
- Assembles two consecutive 12-bit half-words into one 24-bit pixel and tags start-of-frame and end-of-line.
- Buffers pixels in a FIFO and presents them on a valid/ready stream to downstream delay/processing logic.
- Measures active frame geometry and reports overflow and framing errors.

Parameters:
- FIFO_DEPTH, 16, pixel FIFO entries; power of two, minimum 4.
- VS_ACTIVE_HIGH, 1, dvi_vs polarity: 1 = high means sync.
- HS_ACTIVE_HIGH, 1, dvi_hs polarity; hs is registered only, with no functional use beyond the status output.

Ports:
- clk  in  1  bus clock, two clk cycles per pixel.
- resetn  in  1  asynchronous, active-low reset; deasserted synchronously to clk upstream.
- dvi_de  in  1  data enable; inputs synchronous to clk.
- dvi_vs  in  1  vertical sync.
- dvi_hs  in  1  horizontal sync.
- dvi_d  in  12  half-pixel data; first cycle is bits [11:0], second cycle is bits [23:12].
- px_data  out  24  pixel.
- px_sof  out  1  first pixel of frame.
- px_eol  out  1  last pixel of line.
- px_valid  out  1  stream valid.
- px_ready  in  1  stream ready.
- clear_status  in  1  one-cycle pulse; clears sticky flags.
- overflow  out  1  sticky: pixel dropped because the FIFO was full.
- half_error  out  1  sticky: de fell after an odd half count.
- hs_seen  out  1  sticky: an active hs edge was observed.
- frame_width  out  12  pixels per line of the last complete frame.
- frame_height  out  12  lines of the last complete frame.
- geom_valid  out  1  one-cycle pulse when frame_width/frame_height update.

Behaviour:
- Reset values:
  - All outputs are 0.
  - State is SEEK; FIFO is empty; holding register is empty.
- Input stage: all dvi_* signals are registered once.
  - vs_edge = registered vs goes inactive-to-active (after polarity).
  - Same rule for hs_edge.
- State machine:
  - SEEK: discard everything. On vs_edge, go to FRAME and set sof_pending=1.
  - FRAME: when de=1, capture half 0 and go to HI.
  - HI:
    - de=1: form pixel {d, lo}, write it to the holding register, return to FRAME.
    - de=0: drop half 0, set half_error, go to FRAME.
  - DROP: entered on overflow. Discard until vs_edge, then go to FRAME with sof_pending=1.
  - vs_edge in any state: discard any pending half and start a new frame.
- Holding register: one-pixel delay so eol can be known.
  - A held pixel is pushed to the FIFO when the next pixel completes (eol=0) or on the de falling edge (eol=1).
  - sof equals sof_pending at capture; sof_pending clears after the first captured pixel.
  - A held pixel still present at vs_edge is pushed with eol=1.
- FIFO:
  - Write when a push occurs. Read when px_valid && px_ready.
  - Simultaneous read and write when full is allowed: read frees a slot in the same cycle.
  - Push while full and not reading: drop the pixel, set overflow, enter DROP. The frame remainder is not delivered.
  - px_valid = FIFO not empty, driven from registered output.
  - px_data/px_sof/px_eol stay stable while px_valid && !px_ready.
- Geometry:
  - pix_cnt counts pixels in the current line, saturating at 4095. line_cnt counts lines with at least one pixel, saturating at 4095.
  - On vs_edge from FRAME with line_cnt>0:
    - frame_width = width of the last line.
    - frame_height = line_cnt.
    - Pulse geom_valid.
  - No update from SEEK or DROP.
- Status flags:
  - Sticky flags are set by events and cleared by clear_status.
  - If set and clear occur in the same cycle, set wins.
- Latency: a pixel appears on px_valid 3 clk after its second half reaches dvi_d, with the FIFO empty and the next pixel following immediately. For eol pixels the count is from the de falling edge.
- Reset mid-frame: return immediately to reset values. The first pixel delivered after reset is only after a fresh vs_edge.

Decomposition:
- Package dvi_pkg:
  - rx_state_t enum {SEEK, FRAME, HI, DROP}.
  - Typedef pixel_t = 24-bit.
  - Typedef fifo_word_t struct {pixel_t data; logic sof; logic eol;}.
  - Constant GEOM_W=12.
- Sub-module sync_fifo (parameterised width/depth, registered output, full/empty).

Test Plan:
- Reset, then a vs pulse, then 2 lines of 4 pixels (halves 0x001/0x002, ...), with px_ready=1 → 8 pixels delivered.
  - First pixel is 0x002001 with sof=1.
  - Pixels 4 and 8 have eol=1.
  - Next vs gives frame_width=4, frame_height=2, and a geom_valid pulse.
- Stream driven before any vs → nothing delivered and geom_valid is not pulsed.
- de high for 3 halves, then low → 1 pixel delivered with eol=1, half_error=1.
  - clear_status clears half_error.
- px_ready=0 and a 40-pixel line with FIFO_DEPTH=16 → overflow=1.
  - Exactly 16 pixels are delivered after ready rises; rest of frame is dropped.
  - Next frame is delivered intact with sof=1.
- px_ready toggling every cycle → px_data is held while stalled, with no loss or duplication across 3 frames of 16x4.
- resetn asserted mid-line → all outputs 0 the same cycle; delivery resumes only after the next vs_edge.
